// File: rtl/multi_ch_acq_ctrl_if.sv
// Bus bundle for the multi-channel acquisition controller: sample input, trigger setup,
// run control and the record-memory write port with capture status.
`timescale 1ns / 1ps

interface multi_ch_acq_ctrl_if #(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned SAMPLE_W = 8,
  parameter int unsigned ADDR_W   = 17
);
  localparam int unsigned SRC_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                       sample_valid;
  logic [NUM_CH*SAMPLE_W-1:0] adc_samples;
  logic [SRC_W-1:0]           trig_src;
  logic [SAMPLE_W-1:0]        trig_level;
  logic                       trig_slope;
  logic [1:0]                 mode;
  logic                       arm;
  logic                       abort;
  logic                       done_ack;

  logic                       mem_we;
  logic [ADDR_W-1:0]          mem_addr;
  logic [NUM_CH*SAMPLE_W-1:0] mem_wdata;
  logic [ADDR_W-1:0]          trig_addr;
  logic [ADDR_W-1:0]          start_addr;
  logic                       capture_done;
  logic                       auto_trig;
  logic [2:0]                 acq_state;

  modport slave (
    input  sample_valid, adc_samples, trig_src, trig_level, trig_slope, mode,
    input  arm, abort, done_ack,
    output mem_we, mem_addr, mem_wdata, trig_addr, start_addr, capture_done, auto_trig,
    output acq_state
  );

  modport master (
    output sample_valid, adc_samples, trig_src, trig_level, trig_slope, mode,
    output arm, abort, done_ack,
    input  mem_we, mem_addr, mem_wdata, trig_addr, start_addr, capture_done, auto_trig,
    input  acq_state
  );
endinterface

// File: rtl/multi_ch_acq_ctrl.sv
// Pre/post-trigger acquisition controller: streams sample sets into a circular record
// memory, detects a level crossing on one channel and freezes a DEPTH-sample record.
`timescale 1ns / 1ps

module multi_ch_acq_ctrl #(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned SAMPLE_W = 8,
  parameter int unsigned ADDR_W   = 17,
  parameter int unsigned PRE_TRIG = 1024,
  parameter int unsigned AUTO_TO  = 65535
) (
  input logic                clk_50,
  input logic                reset_n,
  multi_ch_acq_ctrl_if.slave bus
);
  localparam int unsigned SRC_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned POST_N = DEPTH - PRE_TRIG - 1;

  localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRE_TRIG - 1);
  localparam logic [ADDR_W-1:0] PRE_OFS   = ADDR_W'(PRE_TRIG);
  localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'(POST_N - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [31:0]       TO_LAST   = 32'(AUTO_TO - 1);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StPre   = 3'd1,
    StArmed = 3'd2,
    StPost  = 3'd3,
    StDone  = 3'd4
  } state_e;

  state_e                     state_q;
  logic                       we_q;
  logic [ADDR_W-1:0]          addr_q;
  logic [NUM_CH*SAMPLE_W-1:0] wdata_q;
  logic [ADDR_W-1:0]          trig_addr_q;
  logic [ADDR_W-1:0]          start_addr_q;
  logic                       done_q;
  logic                       auto_q;
  logic [ADDR_W-1:0]          wr_ptr_q;
  logic [ADDR_W-1:0]          pre_cnt_q;
  logic [ADDR_W-1:0]          post_cnt_q;
  logic [31:0]                to_cnt_q;
  logic [SAMPLE_W-1:0]        prev_q;
  logic                       prev_vld_q;

  logic [SAMPLE_W-1:0] cur;
  logic                edge_hit;
  logic                timeout;
  logic                restart;
  logic                capturing;

  // Out-of-range channel indices fall back to channel 0.
  always_comb begin
    cur = bus.adc_samples[SAMPLE_W-1:0];
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (bus.trig_src == SRC_W'(c)) cur = bus.adc_samples[c*SAMPLE_W +: SAMPLE_W];
    end
  end

  always_comb begin
    edge_hit = 1'b0;
    if (prev_vld_q) begin
      if (bus.trig_slope) edge_hit = (prev_q < bus.trig_level) && (cur >= bus.trig_level);
      else                edge_hit = (prev_q > bus.trig_level) && (cur <= bus.trig_level);
    end
  end

  always_comb begin
    timeout   = (bus.mode == 2'b00) && (to_cnt_q == TO_LAST);
    capturing = (state_q == StPre) || (state_q == StArmed) || (state_q == StPost);
    restart   = 1'b0;
    if (state_q == StIdle)      restart = bus.arm;
    else if (state_q == StDone) restart = (bus.mode == 2'b10) ? bus.arm : bus.done_ack;
  end

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      trig_addr_q  <= '0;
      start_addr_q <= '0;
      done_q       <= 1'b0;
      auto_q       <= 1'b0;
      wr_ptr_q     <= '0;
      pre_cnt_q    <= '0;
      post_cnt_q   <= '0;
      to_cnt_q     <= '0;
      prev_q       <= '0;
      prev_vld_q   <= 1'b0;
    end else begin
      we_q <= 1'b0;
      if (bus.abort) begin
        state_q <= StIdle;
        done_q  <= 1'b0;
      end else if (restart) begin
        state_q    <= StPre;
        done_q     <= 1'b0;
        auto_q     <= 1'b0;
        wr_ptr_q   <= '0;
        pre_cnt_q  <= '0;
        post_cnt_q <= '0;
        to_cnt_q   <= '0;
        prev_vld_q <= 1'b0;
      end else if (capturing && bus.sample_valid) begin
        we_q       <= 1'b1;
        addr_q     <= wr_ptr_q;
        wdata_q    <= bus.adc_samples;
        wr_ptr_q   <= wr_ptr_q + ADDR_ONE;
        prev_q     <= cur;
        prev_vld_q <= 1'b1;
        case (state_q)
          StPre: begin
            if (pre_cnt_q == PRE_LAST) state_q <= StArmed;
            else                       pre_cnt_q <= pre_cnt_q + ADDR_ONE;
          end
          StArmed: begin
            // A real edge on the timeout strobe still counts as a genuine trigger.
            if (edge_hit || timeout) begin
              trig_addr_q  <= wr_ptr_q;
              start_addr_q <= wr_ptr_q - PRE_OFS;
              auto_q       <= !edge_hit;
              post_cnt_q   <= '0;
              if (POST_N == 0) begin
                state_q <= StDone;
                done_q  <= 1'b1;
              end else begin
                state_q <= StPost;
              end
            end else if (to_cnt_q != TO_LAST) begin
              to_cnt_q <= to_cnt_q + 32'd1;
            end
          end
          StPost: begin
            if (post_cnt_q == POST_LAST) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              post_cnt_q <= post_cnt_q + ADDR_ONE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.mem_we       = we_q;
  assign bus.mem_addr     = addr_q;
  assign bus.mem_wdata    = wdata_q;
  assign bus.trig_addr    = trig_addr_q;
  assign bus.start_addr   = start_addr_q;
  assign bus.capture_done = done_q;
  assign bus.auto_trig    = auto_q;
  assign bus.acq_state    = state_q;

endmodule

// File: tb/tb_multi_ch_acq_ctrl.sv
// Bench for multi_ch_acq_ctrl: vector table, directed record scenarios and random traffic
// checked against a count-based record model.
`timescale 1ns / 1ps

module tb_multi_ch_acq_ctrl;
  localparam int unsigned NUM_CH   = 2;
  localparam int unsigned SAMPLE_W = 8;
  localparam int unsigned ADDR_W   = 4;
  localparam int unsigned PRE_TRIG = 4;
  localparam int unsigned AUTO_TO  = 8;
  localparam int DEPTH  = 16;
  localparam int POST_N = DEPTH - PRE_TRIG - 1;

  logic clk_50 = 1'b0;
  logic reset_n = 1'b0;
  always #10 clk_50 = ~clk_50;

  multi_ch_acq_ctrl_if #(.NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .ADDR_W(ADDR_W)) bus ();

  multi_ch_acq_ctrl #(
    .NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .ADDR_W(ADDR_W),
    .PRE_TRIG(PRE_TRIG), .AUTO_TO(AUTO_TO)
  ) dut (
    .clk_50 (clk_50),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int n_chk = 0;
  int n_pass = 0;
  int last_addr = 0;
  int w_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Record model: phase derives from write count since arm and the trigger index.
  bit          m_run;
  int          m_n, m_trig, m_acnt;
  logic [7:0]  m_prev;
  bit          m_prev_ok;
  int          m_ta, m_sa;
  bit          m_auto, m_we;
  int          m_addr;
  logic [15:0] m_data;

  function automatic int m_phase();
    if (!m_run) return 0;
    if (m_n < PRE_TRIG) return 1;
    if (m_trig < 0) return 2;
    if (m_n - m_trig - 1 < POST_N) return 3;
    return 4;
  endfunction

  task automatic m_start();
    m_run = 1; m_n = 0; m_trig = -1; m_acnt = 0; m_prev_ok = 0; m_auto = 0;
  endtask

  task automatic m_reset();
    m_run = 0; m_we = 0; m_addr = 0; m_data = 0; m_ta = 0; m_sa = 0; m_auto = 0;
    m_prev_ok = 0; m_n = 0; m_trig = -1; m_acnt = 0;
  endtask

  task automatic m_step();
    int p;
    logic [7:0] cur, lvl;
    bit e;
    p = m_phase();
    m_we = 0;
    lvl = bus.trig_level;
    if (bus.abort) m_run = 0;
    else if (p == 0) begin
      if (bus.arm) m_start();
    end else if (p == 4) begin
      if ((bus.mode == 2'b10) ? bus.arm : bus.done_ack) m_start();
    end else if (bus.sample_valid) begin
      cur = bus.trig_src[0] ? bus.adc_samples[15:8] : bus.adc_samples[7:0];
      e = m_prev_ok && (bus.trig_slope ? (m_prev < lvl && cur >= lvl)
                                       : (m_prev > lvl && cur <= lvl));
      m_we = 1; m_addr = m_n % DEPTH; m_data = bus.adc_samples;
      if (p == 2) begin
        if (e || (bus.mode == 2'b00 && m_acnt + 1 >= AUTO_TO)) begin
          m_trig = m_n;
          m_ta = m_n % DEPTH;
          m_sa = (m_n % DEPTH - PRE_TRIG + DEPTH) % DEPTH;
          m_auto = !e;
        end else m_acnt++;
      end
      m_n++; m_prev = cur; m_prev_ok = 1;
    end
  endtask

  task automatic check_all();
    chk("we", bus.mem_we, m_we);
    if (m_we) begin
      chk("addr", bus.mem_addr, m_addr);
      chk("wdata", bus.mem_wdata, m_data);
    end
    chk("state", bus.acq_state, m_phase());
    chk("done", bus.capture_done, m_phase() == 4);
    chk("trig_addr", bus.trig_addr, m_ta);
    chk("start_addr", bus.start_addr, m_sa);
    chk("auto_trig", bus.auto_trig, m_auto);
  endtask

  task automatic cyc(input bit sv, input logic [7:0] c0, input logic [7:0] c1,
                     input bit arm_i, input bit abort_i, input bit ack_i);
    bus.sample_valid = sv;
    bus.adc_samples  = {c1, c0};
    bus.arm          = arm_i;
    bus.abort        = abort_i;
    bus.done_ack     = ack_i;
    @(posedge clk_50);
    m_step();
    #1;
    check_all();
    if (bus.mem_we) begin
      last_addr = bus.mem_addr;
      w_cnt++;
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_we"}, bus.mem_we, 0);
    chk({tag, "_addr"}, bus.mem_addr, 0);
    chk({tag, "_wdata"}, bus.mem_wdata, 0);
    chk({tag, "_trig"}, bus.trig_addr, 0);
    chk({tag, "_start"}, bus.start_addr, 0);
    chk({tag, "_done"}, bus.capture_done, 0);
    chk({tag, "_auto"}, bus.auto_trig, 0);
    chk({tag, "_state"}, bus.acq_state, 0);
  endtask

  task automatic do_reset();
    @(negedge clk_50);
    reset_n = 1'b0;
    m_reset();
    #2;
    check_zero("rst");
    @(negedge clk_50);
    reset_n = 1'b1;
  endtask

  task automatic set_trig(input logic [1:0] md, input bit slope, input bit src,
                          input logic [7:0] lvl);
    bus.mode = md; bus.trig_slope = slope; bus.trig_src = src; bus.trig_level = lvl;
  endtask

  typedef struct {
    bit         sv;
    logic [7:0] c0;
    bit         arm;
    bit         abort;
    int         st;
    bit         we;
    int         addr;
    int         ta;
  } vec_t;

  vec_t tbl [11];

  initial begin
    logic [7:0] v, c0, c1;
    bit fin, quiet;

    tbl[0]  = '{0, 8'h00, 1, 1, 0, 0, 0, -1};
    tbl[1]  = '{0, 8'h00, 1, 0, 1, 0, 0, -1};
    tbl[2]  = '{1, 8'h00, 0, 0, 1, 1, 0, -1};
    tbl[3]  = '{1, 8'h90, 0, 0, 1, 1, 1, -1};
    tbl[4]  = '{1, 8'h10, 0, 0, 1, 1, 2, -1};
    tbl[5]  = '{0, 8'h10, 0, 0, 1, 0, 0, -1};
    tbl[6]  = '{1, 8'h20, 0, 0, 2, 1, 3, -1};
    tbl[7]  = '{1, 8'h30, 1, 0, 2, 1, 4, -1};
    tbl[8]  = '{1, 8'h90, 0, 0, 3, 1, 5, 5};
    tbl[9]  = '{1, 8'h40, 0, 1, 0, 0, 0, 5};
    tbl[10] = '{1, 8'h50, 0, 0, 0, 0, 0, 5};

    bus.sample_valid = 0; bus.adc_samples = '0; bus.arm = 0; bus.abort = 0;
    bus.done_ack = 0;
    set_trig(2'b01, 1, 0, 8'h80);
    m_reset();
    do_reset();

    // Arm/abort priority, PRE edge ignored, ARMED trigger, abort in POST.
    for (int i = 0; i < 11; i++) begin
      cyc(tbl[i].sv, tbl[i].c0, 8'h00, tbl[i].arm, tbl[i].abort, 1'b0);
      chk($sformatf("tbl%0d_state", i), bus.acq_state, tbl[i].st);
      chk($sformatf("tbl%0d_we", i), bus.mem_we, tbl[i].we);
      if (tbl[i].we) chk($sformatf("tbl%0d_addr", i), bus.mem_addr, tbl[i].addr);
      if (tbl[i].ta >= 0) chk($sformatf("tbl%0d_trig", i), bus.trig_addr, tbl[i].ta);
    end

    // Normal rising ramp with wrap.
    do_reset();
    set_trig(2'b01, 1, 0, 8'h80);
    cyc(0, 0, 0, 1, 0, 0);
    w_cnt = 0; v = 8'h00; fin = 0;
    for (int i = 0; i < 60 && !fin; i++) begin
      cyc(1, v, 8'h00, 0, 0, 0);
      v += 8'h10;
      cyc(0, v, 8'h00, 0, 0, 0);
      fin = bus.capture_done;
    end
    chk("ramp_done", fin, 1);
    chk("ramp_trig", bus.trig_addr, 8);
    chk("ramp_start", bus.start_addr, 4);
    chk("ramp_last", last_addr, 3);
    chk("ramp_writes", w_cnt, 20);
    chk("ramp_auto", bus.auto_trig, 0);

    // Auto timeout on a flat signal.
    cyc(0, 0, 0, 0, 1, 0);
    set_trig(2'b00, 1, 0, 8'h80);
    cyc(0, 0, 0, 1, 0, 0);
    w_cnt = 0; fin = 0;
    for (int i = 0; i < 60 && !fin; i++) begin
      cyc(1, 8'h10, 8'h10, 0, 0, 0);
      fin = bus.capture_done;
    end
    chk("auto_done", fin, 1);
    chk("auto_flag", bus.auto_trig, 1);
    chk("auto_trig", bus.trig_addr, 11);
    chk("auto_start", bus.start_addr, 7);
    chk("auto_writes", w_cnt, 23);

    // Falling edge on channel 1 while channel 0 rises through the level.
    cyc(0, 0, 0, 0, 1, 0);
    set_trig(2'b01, 0, 1, 8'h80);
    cyc(0, 0, 0, 1, 0, 0);
    fin = 0;
    for (int i = 0; i < 60 && !fin; i++) begin
      c0 = 8'(i * 32);
      c1 = (i < 6) ? 8'hF0 : 8'h20;
      cyc(1, c0, c1, 0, 0, 0);
      fin = bus.capture_done;
    end
    chk("fall_done", fin, 1);
    chk("fall_trig", bus.trig_addr, 6);
    chk("fall_start", bus.start_addr, 2);

    // Single mode: done_ack ignored, arm restarts at address 0.
    cyc(0, 0, 0, 0, 1, 0);
    set_trig(2'b10, 1, 0, 8'h80);
    cyc(0, 0, 0, 1, 0, 0);
    v = 8'h00; fin = 0;
    for (int i = 0; i < 60 && !fin; i++) begin
      cyc(1, v, 8'h00, 0, 0, 0);
      v += 8'h10;
      fin = bus.capture_done;
    end
    chk("single_done", fin, 1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("single_ack_state", bus.acq_state, 4);
    cyc(0, 0, 0, 1, 0, 0);
    chk("single_rearm_state", bus.acq_state, 1);
    cyc(1, 8'h55, 8'hAA, 0, 0, 0);
    chk("single_rearm_we", bus.mem_we, 1);
    chk("single_rearm_addr", bus.mem_addr, 0);

    // Asynchronous reset in POST.
    cyc(0, 0, 0, 0, 1, 0);
    set_trig(2'b01, 1, 0, 8'h80);
    cyc(0, 0, 0, 1, 0, 0);
    v = 8'h00; fin = 0;
    for (int i = 0; i < 40 && !fin; i++) begin
      cyc(1, v, 8'h00, 0, 0, 0);
      v += 8'h10;
      fin = (bus.acq_state == 3);
    end
    chk("post_reached", fin, 1);
    #3;
    reset_n = 1'b0;
    m_reset();
    #1;
    check_zero("async");
    @(negedge clk_50);
    reset_n = 1'b1;
    cyc(0, 0, 0, 1, 0, 0);
    cyc(1, 8'h12, 8'h34, 0, 0, 0);
    chk("after_rst_we", bus.mem_we, 1);
    chk("after_rst_addr", bus.mem_addr, 0);
    chk("after_rst_state", bus.acq_state, 1);

    // Random traffic against the model.
    c0 = 8'h00; c1 = 8'h00; quiet = 0;
    for (int i = 0; i < 4000; i++) begin
      if (i % 200 == 0)
        set_trig(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 8'($urandom));
      if (i % 50 == 0) quiet = ($urandom_range(0, 1) == 1);
      if (!quiet) begin
        c0 = 8'($urandom);
        c1 = 8'($urandom);
      end
      cyc($urandom_range(0, 1) == 1, c0, c1, $urandom_range(0, 15) == 0,
          $urandom_range(0, 99) == 0, $urandom_range(0, 15) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
